perceptron_infer: RTL and testbench

- Inference engine for the 2-input FP16 perceptron. It consumes the weight set produced by the training epoch block and classifies samples one at a time.
- Computes v = w0*1.0 + w1*x1 + w2*x2 in IEEE-754 half precision and outputs y = 1.0 or 0.0.
- Optionally scores y against a label d and keeps an error count.
- Uses a single time-multiplexed multi16 and a single sum16 instance. Sits downstream of the trainer; this is the weight reader / evaluation side of the weight interface.

---
 rtl/perceptron_infer.sv | 179 +++++++++++++++++
 tb/tb_perceptron_infer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_infer.sv
// 2-input FP16 perceptron inference: v = w0 + w1*x1 + w2*x2, y = (v >= +0) ? 1.0 : 0.0.
// One shared FP16 multiplier and adder, sequenced over three accumulate states.
module perceptron_infer #(
  parameter int tam   = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [tam-1:0]   w0_in,
  input  logic [tam-1:0]   w1_in,
  input  logic [tam-1:0]   w2_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [tam-1:0]   x1,
  input  logic [tam-1:0]   x2,
  input  logic [tam-1:0]   d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [tam-1:0]   v_out,
  output logic [tam-1:0]   y_out,
  output logic             miss,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_count
);

  localparam logic [15:0] ONE = 16'h3C00;

  typedef enum logic [2:0] {NOWGT, READY, ACC0, ACC1, ACC2, OUT} state_t;

  state_t            state_q, state_d;
  logic [15:0]       w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [15:0]       x1_q, x1_d, x2_q, x2_d, dl_q, dl_d;
  logic [15:0]       acc_q, acc_d, v_q, v_d, y_q, y_d;
  logic              miss_q, miss_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       mul_a, mul_b, prod, sum, y_new;

  // Truncating FP16 multiply; subnormal inputs/results flush to signed zero.
  function automatic logic [15:0] multi16(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    logic [9:0]  m;
    logic        s;
    int          e;
    logic [15:0] r;
    s = a[15] ^ b[15];
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11];
      e = e + 1;
    end else begin
      m = p[19:10];
    end
    r = {s, e[4:0], m};
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0 || e <= 0) r = {s, 15'd0};
    else if (e >= 31) r = {s, 5'h1F, 10'd0};
    return r;
  endfunction

  // Truncating FP16 add with three guard bits; exact cancellation yields +0.
  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml, r;
    logic [13:0] mb, ms;
    logic [14:0] s;
    int          e, sh;
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    mb = {1'b1, big[9:0], 3'b000};
    sh = int'(big[14:10]) - int'(sml[14:10]);
    ms = (sh > 13) ? 14'd0 : ({1'b1, sml[9:0], 3'b000} >> sh);
    e  = int'(big[14:10]);
    if (big[15] == sml[15]) begin
      s = {1'b0, mb} + {1'b0, ms};
      if (s[14]) begin
        s = s >> 1;
        e = e + 1;
      end
    end else begin
      s = {1'b0, mb - ms};
      for (int i = 0; i < 13; i++) begin
        if (!s[13] && s != 15'd0) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    r = {big[15], e[4:0], s[12:3]};
    if (big[14:10] == 5'd0) r = {big[15] & sml[15], 15'd0};
    else if (sml[14:10] == 5'd0) r = big;
    else if (s == 15'd0) r = 16'd0;
    else if (e >= 31) r = {big[15], 5'h1F, 10'd0};
    else if (e <= 0) r = {big[15], 15'd0};
    return r;
  endfunction

  assign mul_a = (state_q == ACC2) ? x2_q : x1_q;
  assign mul_b = (state_q == ACC2) ? w2_q : w1_q;
  assign prod  = multi16(mul_a, mul_b);
  assign sum   = sum16(acc_q, prod);
  assign y_new = sum[15] ? 16'h0000 : ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NOWGT;
      w0_q <= '0; w1_q <= '0; w2_q <= '0;
      x1_q <= '0; x2_q <= '0; dl_q <= '0;
      acc_q <= '0; v_q <= '0; y_q <= '0;
      miss_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      w0_q <= w0_d; w1_q <= w1_d; w2_q <= w2_d;
      x1_q <= x1_d; x2_q <= x2_d; dl_q <= dl_d;
      acc_q <= acc_d; v_q <= v_d; y_q <= y_d;
      miss_q <= miss_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NOWGT:   if (w_valid) state_d = READY;
      READY:   if (!w_valid && in_valid) state_d = ACC0;
      ACC0:    state_d = ACC1;
      ACC1:    state_d = ACC2;
      ACC2:    state_d = OUT;
      OUT:     if (out_ready) state_d = READY;
      default: state_d = NOWGT;
    endcase
  end

  always_comb begin
    w_ready   = (state_q == NOWGT) || (state_q == READY);
    in_ready  = (state_q == READY) && !w_valid;
    out_valid = (state_q == OUT);
  end

  always_comb begin
    w0_d = w0_q; w1_d = w1_q; w2_d = w2_q;
    x1_d = x1_q; x2_d = x2_q; dl_d = dl_q;
    acc_d = acc_q; v_d = v_q; y_d = y_q;
    miss_d = miss_q;
    cnt_d = cnt_q;
    if (w_valid && w_ready) begin
      w0_d = w0_in; w1_d = w1_in; w2_d = w2_in;
    end
    if (in_valid && in_ready) begin
      x1_d = x1; x2_d = x2; dl_d = d;
    end
    case (state_q)
      ACC0: acc_d = w0_q;
      ACC1: acc_d = sum;
      ACC2: begin
        acc_d  = sum;
        v_d    = sum;
        y_d    = y_new;
        miss_d = (y_new != dl_q);
      end
      default: ;
    endcase
    // Clear wins over a same-cycle increment.
    if (clr_count) cnt_d = '0;
    else if (state_q == OUT && out_ready && miss_q && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  assign v_out     = v_q;
  assign y_out     = y_q;
  assign miss      = miss_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_perceptron_infer.sv
// Scoreboard bench for perceptron_infer: directed samples with hand-computed FP16 results.
module tb_perceptron_infer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_count = 1'b0;
  logic [15:0] w0_in = '0, w1_in = '0, w2_in = '0, x1 = '0, x2 = '0, d = '0;
  logic        w_ready, in_ready, out_valid, miss;
  logic [15:0] v_out, y_out;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [15:0] v;
    logic [15:0] y;
    logic        m;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  perceptron_infer #(.tam(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready),
    .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .v_out(v_out), .y_out(y_out), .miss(miss),
    .err_count(err_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: compare each result as it is handed downstream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          chk("v_out", v_out, e.v);
          chk("y_out", y_out, e.y);
          chk("miss", {15'd0, miss}, {15'd0, e.m});
        end
      end
    end
  end

  task automatic send_w(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic rdy;
    logic got;
    got = 1'b0;
    @(negedge clk);
    w_valid = 1'b1; w0_in = a; w1_in = b; w2_in = c;
    for (int n = 0; n < 100 && !got; n++) begin
      #1 rdy = w_ready;
      @(posedge clk);
      if (rdy) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) timeout("weight_accept");
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic send_x(input logic [15:0] a, input logic [15:0] b, input logic [15:0] dd,
                        input logic [15:0] ev, input logic [15:0] ey, input logic em);
    logic rdy;
    logic got;
    got = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; x1 = a; x2 = b; d = dd;
    for (int n = 0; n < 100 && !got; n++) begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) got = 1'b1;
      else @(negedge clk);
    end
    if (got) exp_q.push_back('{v: ev, y: ey, m: em});
    else timeout("sample_accept");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("drain");
    @(negedge clk);
    #3;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    #3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w_ready"}, {15'd0, w_ready}, 16'd1);
    chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd0);
    chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_v_out"}, v_out, 16'h0000);
    chk({tag, "_y_out"}, y_out, 16'h0000);
    chk({tag, "_miss"}, {15'd0, miss}, 16'd0);
    chk({tag, "_err_count"}, {8'd0, err_count}, 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #3 chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Samples are refused until weights exist.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      chk("noweight_in_ready", {15'd0, in_ready}, 16'd0);
      chk("noweight_out_valid", {15'd0, out_valid}, 16'd0);
    end
    in_valid = 1'b0;

    // -0.5 + 0 + 0 = -0.5, negative -> y=0; latency check on out_valid.
    out_ready = 1'b1;
    send_w(16'hB800, 16'h3C00, 16'h3C00);
    send_x(16'h0000, 16'h0000, 16'h0000, 16'hB800, 16'h0000, 1'b0);
    #3 chk("lat_acc0", {15'd0, out_valid}, 16'd0);
    @(negedge clk); #3 chk("lat_acc1", {15'd0, out_valid}, 16'd0);
    @(negedge clk); #3 chk("lat_acc2", {15'd0, out_valid}, 16'd0);
    @(negedge clk); #3 chk("lat_out", {15'd0, out_valid}, 16'd1);
    drain();

    send_x(16'h3C00, 16'h0000, 16'h3C00, 16'h3800, 16'h3C00, 1'b0);
    send_x(16'h0000, 16'h3C00, 16'h3C00, 16'h3800, 16'h3C00, 1'b0);
    send_x(16'h3C00, 16'h3C00, 16'h3C00, 16'h3E00, 16'h3C00, 1'b0);
    drain();
    chk("err_after_hits", {8'd0, err_count}, 16'd0);

    // +0.5 bias alone: y=1 against d=0 is a miss.
    send_w(16'h3800, 16'h0000, 16'h0000);
    send_x(16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h3C00, 1'b1);
    drain();
    chk("err_one_miss", {8'd0, err_count}, 16'd1);
    pulse_clr();
    chk("err_cleared", {8'd0, err_count}, 16'd0);

    // Backpressure holds the result and blocks both inputs.
    out_ready = 1'b0;
    send_x(16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h3C00, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk); #3;
        n++;
      end
      if (n >= 20) timeout("bp_out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
      chk("bp_v_out", v_out, 16'h3800);
      chk("bp_y_out", y_out, 16'h3C00);
      chk("bp_w_ready", {15'd0, w_ready}, 16'd0);
      chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk); #3;
    chk("rel_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rel_w_ready", {15'd0, w_ready}, 16'd1);
    chk("rel_in_ready", {15'd0, in_ready}, 16'd1);
    chk("hold_v_out", v_out, 16'h3800);
    chk("hold_y_out", y_out, 16'h3C00);
    chk("err_bp", {8'd0, err_count}, 16'd1);

    // Weights and sample offered together: weights first, sample next cycle.
    @(negedge clk);
    w_valid = 1'b1; w0_in = 16'hB800; w1_in = 16'h3C00; w2_in = 16'h3C00;
    in_valid = 1'b1; x1 = 16'h3C00; x2 = 16'h3C00; d = 16'h3C00;
    #1;
    chk("both_w_ready", {15'd0, w_ready}, 16'd1);
    chk("both_in_ready", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    w_valid = 1'b0;
    #1 chk("next_in_ready", {15'd0, in_ready}, 16'd1);
    exp_q.push_back('{v: 16'h3E00, y: 16'h3C00, m: 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    #3 chk("sample_taken", {15'd0, in_ready}, 16'd0);
    drain();

    // Reset during ACC1 aborts and forgets the weights.
    send_x(16'h3C00, 16'h0000, 16'h0000, 16'h3800, 16'h3C00, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      chk("postreset_in_ready", {15'd0, in_ready}, 16'd0);
      chk("postreset_out_valid", {15'd0, out_valid}, 16'd0);
    end
    in_valid = 1'b0;

    // 256 misses must saturate the counter at 255.
    send_w(16'h3800, 16'h0000, 16'h0000);
    for (int i = 0; i < 256; i++)
      send_x(16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h3C00, 1'b1);
    drain();
    chk("err_saturated", {8'd0, err_count}, 16'd255);
    pulse_clr();
    chk("err_cleared_sat", {8'd0, err_count}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
